// File: rtl/conv_stream_adapter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_stream_adapter_pkg
//  Description : Shared FSM state encoding and default bus width for the
//                converter stream adapter.
//  Revision    : 1.0
// ============================================================================
package conv_stream_adapter_pkg;

    localparam int unsigned c_DW_DEFAULT = 8;
    localparam int unsigned c_ST_W       = 2;

    typedef enum logic [c_ST_W-1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_stream_adapter_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : conv_stream_adapter_sync_fifo
//  Description : Single-clock FIFO holding {mode,data} words ahead of the
//                converter sequencer. No write-to-read bypass.
//  Revision    : 1.0
// ============================================================================
module conv_stream_adapter_sync_fifo #(
    parameter int DW         = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic            w_push_ok;
    logic            w_pop_ok;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= din;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : conv_stream_adapter
//  Description : Buffers words from a valid/ready stream, sequences one
//                converter start/done exchange per word and returns results
//                on a valid/ready stream with a sticky timeout flag.
//  Revision    : 1.0
// ============================================================================
module conv_stream_adapter
    import conv_stream_adapter_pkg::*;
#(
    parameter int DW          = c_DW_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_mode,
    output logic [DW-1:0] cv_data_in,
    output logic          cv_start,
    output logic          cv_convert,
    input  logic [DW-1:0] cv_data_out,
    input  logic          cv_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_mode,
    output logic          busy,
    output logic          timeout_err
);

    localparam int c_CW = $clog2(TIMEOUT_CYC) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rdy_en;
    logic            r_done_q;
    logic            r_timeout;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_inc;
    logic [DW-1:0]   r_cv_data;
    logic            r_cv_mode;
    logic [DW-1:0]   r_out_data;
    logic            r_out_mode;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [DW:0]     w_fifo_dout;
    logic            w_done_rise;
    logic            w_timeout_hit;

    // Held low for the first cycle out of reset so in_ready reads 0 in reset.
    assign in_ready      = r_rdy_en & ~w_fifo_full;
    assign w_push        = in_valid & in_ready;
    assign w_done_rise   = cv_done & ~r_done_q;
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_timeout_hit = (w_cnt_inc == c_CW'(TIMEOUT_CYC - 1));

    conv_stream_adapter_sync_fifo #(
        .DW         (DW + 1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({in_mode, in_data}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done_rise) begin
                    w_state_nxt = S_HOLD;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdy_en   <= 1'b0;
            r_done_q   <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_cv_data  <= '0;
            r_cv_mode  <= 1'b0;
            r_out_data <= '0;
            r_out_mode <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_done_q <= cv_done;
            if (w_pop) begin
                {r_cv_mode, r_cv_data} <= w_fifo_dout;
            end
            // Done edge wins over the timeout in the same cycle.
            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_done_rise) begin
                r_cnt <= w_cnt_inc;
                if (w_timeout_hit) begin
                    r_timeout <= 1'b1;
                end
            end
            if (r_state == S_WAIT && w_done_rise) begin
                r_out_data <= cv_data_out;
                r_out_mode <= r_cv_mode;
            end
        end
    end

    assign cv_data_in  = r_cv_data;
    assign cv_convert  = r_cv_mode;
    assign cv_start    = (r_state == S_LAUNCH);
    assign out_valid   = (r_state == S_HOLD);
    assign out_data    = r_out_data;
    assign out_mode    = r_out_mode;
    assign busy        = (r_state != S_IDLE) | ~w_fifo_empty;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire
